// File: rtl/cpu_mref.sv
// rtl/cpu_mref.sv - basic accumulator CPU (fetch/decode/execute), optional indirect addressing via CPU_MREF_INDIRECT_EN
module cpu_mref #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_dbg,
  output logic [DATA_W-1:0] ac_dbg
);

  typedef enum logic [2:0] {T0, T1, T2, T3, E1, E2, E3, HALT} state_t;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_BSA = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;
  localparam logic [2:0] OP_RRF = 3'd7;

  localparam logic [ADDR_W-1:0] A_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] D_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] ar_q, ar_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] ac_q, ac_d;
  logic [DATA_W-1:0] dr_q, dr_d;
  logic              e_q, e_d;

  logic              ind_w;
  logic [2:0]        op_w;
  logic [11:0]       rr_w;
  logic [DATA_W:0]   sum_w;

  assign ind_w = ir_q[DATA_W-1];
  assign op_w  = ir_q[DATA_W-2:DATA_W-4];
  assign rr_w  = ir_q[11:0];
  assign sum_w = {1'b0, ac_q} + {1'b0, dr_q};

  assign mem_addr = ar_q;
  assign pc_dbg   = pc_q;
  assign ac_dbg   = ac_q;
  assign halted   = (state_q == HALT);
  assign mem_we   = ((state_q == E1) && ((op_w == OP_STA) || (op_w == OP_BSA))) ||
                    (state_q == E3);

  // Write data is only non-zero in the three write cycles.
  always_comb begin
    mem_wdata = '0;
    if (state_q == E1 && op_w == OP_STA) begin
      mem_wdata = ac_q;
    end else if (state_q == E1 && op_w == OP_BSA) begin
      mem_wdata = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
    end else if (state_q == E3) begin
      mem_wdata = dr_q;
    end
  end

  // Next-state and datapath updates for the instruction cycle.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ar_d    = ar_q;
    ir_d    = ir_q;
    ac_d    = ac_q;
    dr_d    = dr_q;
    e_d     = e_q;
    case (state_q)
      T0: begin
        ar_d    = pc_q;
        state_d = T1;
      end
      T1: begin
        ir_d    = mem_rdata;
        pc_d    = pc_q + A_ONE;
        state_d = T2;
      end
      T2: begin
        ar_d    = ir_q[ADDR_W-1:0];
        state_d = T3;
      end
      T3: begin
        if (op_w == OP_RRF) begin
          state_d = T0;
          if (!ind_w) begin
            case (rr_w)
              12'b1000_0000_0000: ac_d = '0;
              12'b0100_0000_0000: e_d  = 1'b0;
              12'b0010_0000_0000: ac_d = ~ac_q;
              12'b0001_0000_0000: e_d  = ~e_q;
              12'b0000_1000_0000: begin
                ac_d = {e_q, ac_q[DATA_W-1:1]};
                e_d  = ac_q[0];
              end
              12'b0000_0100_0000: begin
                ac_d = {ac_q[DATA_W-2:0], e_q};
                e_d  = ac_q[DATA_W-1];
              end
              12'b0000_0010_0000: ac_d = ac_q + D_ONE;
              12'b0000_0001_0000: if (!ac_q[DATA_W-1] && (ac_q != '0)) pc_d = pc_q + A_ONE;
              12'b0000_0000_1000: if (ac_q[DATA_W-1]) pc_d = pc_q + A_ONE;
              12'b0000_0000_0100: if (ac_q == '0) pc_d = pc_q + A_ONE;
              12'b0000_0000_0010: if (!e_q) pc_d = pc_q + A_ONE;
              12'b0000_0000_0001: dr_d = ac_q;
              12'b0000_0000_0000: state_d = HALT;
              default: ;
            endcase
          end
        end else begin
`ifdef CPU_MREF_INDIRECT_EN
          // AR already holds the pointer address, so mem_rdata is the pointer.
          if (ind_w) ar_d = mem_rdata[ADDR_W-1:0];
`endif
          state_d = E1;
        end
      end
      E1: begin
        case (op_w)
          OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
            dr_d    = mem_rdata;
            state_d = E2;
          end
          OP_BUN: begin
            pc_d    = ar_q;
            state_d = T0;
          end
          OP_BSA: begin
            ar_d    = ar_q + A_ONE;
            state_d = E2;
          end
          default: state_d = T0;
        endcase
      end
      E2: begin
        state_d = T0;
        case (op_w)
          OP_AND: ac_d = ac_q & dr_q;
          OP_ADD: {e_d, ac_d} = sum_w;
          OP_LDA: ac_d = dr_q;
          OP_BSA: pc_d = ar_q;
          OP_ISZ: begin
            dr_d    = dr_q + D_ONE;
            state_d = E3;
          end
          default: ;
        endcase
      end
      E3: begin
        if (dr_q == '0) pc_d = pc_q + A_ONE;
        state_d = T0;
      end
      HALT: state_d = HALT;
      default: state_d = T0;
    endcase
  end

  // State and architectural registers; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= T0;
      pc_q    <= '0;
      ar_q    <= '0;
      ir_q    <= '0;
      ac_q    <= '0;
      dr_q    <= '0;
      e_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ar_q    <= ar_d;
      ir_q    <= ir_d;
      ac_q    <= ac_d;
      dr_q    <= dr_d;
      e_q     <= e_d;
    end
  end

endmodule

// File: tb/tb_cpu_mref.sv
// tb/tb_cpu_mref.sv - scoreboard bench for cpu_mref with a behavioural memory
module tb_cpu_mref;
  localparam int DW = 16;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          halted;
  logic [AW-1:0] pc_dbg;
  logic [DW-1:0] ac_dbg;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;

  typedef struct {
    bit            is_halt;
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  bit   prev_halted = 1'b0;

  always #5 clk = ~clk;

  cpu_mref #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .halted(halted),
    .pc_dbg(pc_dbg), .ac_dbg(ac_dbg)
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  always @(posedge clk) begin
    if (rst) cyc = 0;
    else cyc = cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT writes memory or enters HALT.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_halted = 1'b0;
    end else begin
      if (!mem_we) check("wdata_idle", 32'(mem_wdata), 32'h0);
      if (mem_we) begin
        if (sb.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_write: got addr %h data %h at cycle %0d expected none", mem_addr, mem_wdata, cyc + 1);
        end else begin
          e = sb.pop_front();
          check("wr_kind", 32'(e.is_halt), 32'h0);
          check("wr_addr", 32'(mem_addr), 32'(e.addr));
          check("wr_data", 32'(mem_wdata), 32'(e.data));
          check("wr_cycle", 32'(cyc + 1), 32'(e.cyc));
        end
      end
      if (halted && !prev_halted) begin
        if (sb.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_halt: got halt at cycle %0d expected none", cyc + 1);
        end else begin
          e = sb.pop_front();
          check("halt_kind", 32'(e.is_halt), 32'h1);
          check("halt_cycle", 32'(cyc + 1), 32'(e.cyc));
          check("halt_pc", 32'(pc_dbg), 32'(e.addr));
          check("halt_ac", 32'(ac_dbg), 32'(e.data));
        end
      end
      prev_halted = halted;
    end
  end

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic exp_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input int c);
    exp_t e;
    e.is_halt = 1'b0; e.cyc = c; e.addr = a; e.data = d;
    sb.push_back(e);
  endtask

  task automatic exp_halt(input int c, input logic [AW-1:0] pc, input logic [DW-1:0] ac);
    exp_t e;
    e.is_halt = 1'b1; e.cyc = c; e.addr = pc; e.data = ac;
    sb.push_back(e);
  endtask

  task automatic run(input string name, input int budget, input logic [AW-1:0] pc_hold);
    int n;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!halted) begin
      vectors++; miscompares++;
      $display("FAIL %s_timeout: got no halt after %0d cycles expected halt", name, budget);
    end
    repeat (3) @(negedge clk);
    check({name, "_hold_pc"}, 32'(pc_dbg), 32'(pc_hold));
    check({name, "_drained"}, 32'(sb.size()), 32'h0);
    sb.delete();
    rst = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] ind_ac;
    repeat (2) @(negedge clk);
    check("rst_pc", 32'(pc_dbg), 32'h0);
    check("rst_ac", 32'(ac_dbg), 32'h0);
    check("rst_addr", 32'(mem_addr), 32'h0);
    check("rst_we", 32'(mem_we), 32'h0);
    check("rst_wdata", 32'(mem_wdata), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);

    // LDA, ADD with carry, HLT
    load(12'h000, 16'h2010); load(12'h001, 16'h1011); load(12'h002, 16'h7000);
    load(12'h010, 16'hFFFF); load(12'h011, 16'h0002);
    exp_halt(17, 12'h003, 16'h0001);
    run("lda_add", 60, 12'h003);

    // Same, then CIR exposes E=1 in AC MSB
    load(12'h002, 16'h7080); load(12'h003, 16'h7000);
    exp_halt(21, 12'h004, 16'h8000);
    run("add_cir", 60, 12'h004);

    // CLA then SZA skips over one HLT
    load(12'h000, 16'h7800); load(12'h001, 16'h7004);
    load(12'h002, 16'h7000); load(12'h003, 16'h7000);
    exp_halt(13, 12'h004, 16'h0000);
    run("sza", 60, 12'h004);

    // CMA, INC wraps to 0, SPA must not skip on zero
    load(12'h000, 16'h7200); load(12'h001, 16'h7020); load(12'h002, 16'h7010);
    load(12'h003, 16'h7000); load(12'h004, 16'h7000);
    exp_halt(17, 12'h004, 16'h0000);
    run("inc_spa", 60, 12'h004);

    // ISZ wraps FFFF to 0, writes in cycle 7, skips to address 2
    load(12'h000, 16'h6020); load(12'h001, 16'h7000); load(12'h002, 16'h7000);
    load(12'h020, 16'hFFFF);
    exp_wr(12'h020, 16'h0000, 7);
    exp_halt(12, 12'h003, 16'h0000);
    run("isz", 60, 12'h003);

    // LDA indirect
    load(12'h000, 16'hA030); load(12'h001, 16'h7000);
    load(12'h030, 16'h0040); load(12'h040, 16'h1234);
`ifdef CPU_MREF_INDIRECT_EN
    ind_ac = 16'h1234;
`else
    ind_ac = 16'h0040;
`endif
    exp_halt(11, 12'h002, ind_ac);
    run("lda_ind", 60, 12'h002);

    // BSA stores return address 1 at 0x50, continues at 0x51
    load(12'h000, 16'h5050); load(12'h051, 16'h7000);
    exp_wr(12'h050, 16'h0001, 5);
    exp_halt(11, 12'h052, 16'h0000);
    run("bsa", 60, 12'h052);

    // Reset during STA write cycle must not commit the write
    load(12'h000, 16'h3060); load(12'h001, 16'h7000); load(12'h060, 16'hBEEF);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("sta_e1_we", 32'(mem_we), 32'h1);
    rst = 1'b1;
    #1;
    check("abort_we", 32'(mem_we), 32'h0);
    check("abort_wdata", 32'(mem_wdata), 32'h0);
    check("abort_addr", 32'(mem_addr), 32'h0);
    check("abort_pc", 32'(pc_dbg), 32'h0);
    check("abort_halted", 32'(halted), 32'h0);
    repeat (2) @(negedge clk);
    check("abort_mem", 32'(mem[12'h060]), 32'h0000BEEF);
    exp_wr(12'h060, 16'h0000, 5);
    exp_halt(10, 12'h002, 16'h0000);
    run("sta_restart", 60, 12'h002);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
